score_ctrl: RTL

SCORE_CTRL -- requirements
Module: score_ctrl

---
 rtl/score_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/score_ctrl.sv
// rtl/score_ctrl.sv - four-requester BCD score accumulator with round-robin arbitration
module score_ctrl #(
  parameter logic [3:0] PTS0 = 4'd1,
  parameter logic [3:0] PTS1 = 4'd2,
  parameter logic [3:0] PTS2 = 4'd3,
  parameter logic [3:0] PTS3 = 4'd5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLR,
  input  logic [3:0]  HIT,
  output logic [15:0] SCORE,
  output logic [3:0]  ACK,
  output logic        BUSY,
  output logic        OVF,
  output logic        LOST
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  hit_q;
  logic [3:0]  pend_q, pend_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] work_q, work_d;
  logic [3:0]  carry_q, carry_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] score_q, score_d;
  logic [3:0]  ack_q, ack_d;
  logic        ovf_q, ovf_d;
  logic        lost_q, lost_d;

  logic [3:0]  edge_w;
  logic [3:0]  done_mask;
  logic        found;
  logic [1:0]  pick;
  logic [1:0]  cand;
  logic [4:0]  sum;
  logic [3:0]  digit;

  assign edge_w = HIT & ~hit_q;

  function automatic logic [3:0] pts_of(input logic [1:0] s);
    case (s)
      2'd0:    pts_of = PTS0;
      2'd1:    pts_of = PTS1;
      2'd2:    pts_of = PTS2;
      default: pts_of = PTS3;
    endcase
  endfunction

  // Round-robin pick: first pending requester at or above ptr, wrapping mod 4
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // One BCD digit add per ADD cycle
  always_comb begin
    digit = work_q[{idx_q, 2'b00} +: 4];
    sum   = {1'b0, digit} + {1'b0, carry_q};
  end

  // Next-state, datapath and pending/drop bookkeeping; CLR overrides everything
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    work_d    = work_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    score_d   = score_q;
    ack_d     = 4'b0000;
    ovf_d     = ovf_q;
    done_mask = 4'b0000;

    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          work_d  = score_q;
          carry_d = pts_of(pick);
          idx_d   = 2'd0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (sum > 5'd9) begin
          work_d[{idx_q, 2'b00} +: 4] = 4'(sum - 5'd10);
          carry_d = 4'd1;
        end else begin
          work_d[{idx_q, 2'b00} +: 4] = sum[3:0];
          carry_d = 4'd0;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
          // Carry out of the top digit means the score would exceed 9999
          if (sum > 5'd9) begin
            work_d = 16'h9999;
            ovf_d  = 1'b1;
          end
        end
      end
      DONE: begin
        score_d   = work_q;
        ack_d     = 4'b0001 << sel_q;
        done_mask = 4'b0001 << sel_q;
        ptr_d     = sel_q + 2'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge re-arms even the bit being retired this cycle
    pend_d = (pend_q & ~done_mask) | edge_w;
    lost_d = |(edge_w & pend_q & ~done_mask);

    if (CLR) begin
      score_d = 16'h0000;
      ovf_d   = 1'b0;
      pend_d  = 4'b0000;
      ptr_d   = 2'd0;
      state_d = IDLE;
      ack_d   = 4'b0000;
      lost_d  = 1'b0;
    end
  end

  // State registers; HIT history tracks HIT even in reset so held lines do not fire
  always_ff @(posedge CLK) begin
    hit_q <= HIT;
    if (RST) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      work_q  <= 16'h0000;
      carry_q <= 4'd0;
      idx_q   <= 2'd0;
      score_q <= 16'h0000;
      ack_q   <= 4'b0000;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
      lost_q  <= lost_d;
    end
  end

  assign SCORE = score_q;
  assign ACK   = ack_q;
  assign BUSY  = (state_q != IDLE);
  assign OVF   = ovf_q;
  assign LOST  = lost_q;

endmodule
